// File: rtl/m_trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret, then
// drains the pipeline, commits mepc/mcause/mtval and redirects fetch.
module m_trap_sequencer #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [3:0]  NO_E_CODE    = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic [3:0]  i_exc_code_fd,
  input  logic [31:0] i_exc_pc_fd,
  input  logic [3:0]  i_exc_code_em,
  input  logic [31:0] i_exc_pc_em,
  input  logic [31:0] i_exc_addr_em,
  input  logic [31:0] i_irq_pending,
  input  logic [31:0] i_mie,
  input  logic [31:0] i_mstatus_lower,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic        i_mret_e,
  input  logic        i_csr_write_en,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_trap_we,
  output logic [31:0] o_trap_cause,
  output logic [31:0] o_trap_epc,
  output logic [31:0] o_trap_tval,
  output logic        o_mret_we,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    COMMIT,
    RET,
    REDIRECT
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [3:0]  count;

  logic [31:0] irq;
  logic        em_valid;
  logic        fd_valid;
  logic        irq_valid;
  logic        trap_event;
  logic [31:0] cap_cause;
  logic [31:0] cap_epc;
  logic [31:0] cap_tval;
  logic [31:0] trap_target;
  logic        unused_bits;

  assign unused_bits = ^{i_mstatus_lower, irq};

  // Fixed-priority pick of the trap to capture: E/M, then F/D, then MEI > MSI > MTI.
  always_comb begin
    irq        = i_irq_pending & i_mie;
    em_valid   = (i_exc_code_em != NO_E_CODE);
    fd_valid   = (i_exc_code_fd != NO_E_CODE);
    irq_valid  = i_mstatus_lower[3] && (irq[11] || irq[3] || irq[7]);
    trap_event = em_valid || fd_valid || irq_valid;
    cap_cause  = 32'd0;
    cap_epc    = 32'd0;
    cap_tval   = 32'd0;
    if (em_valid) begin
      cap_cause = {28'd0, i_exc_code_em};
      cap_epc   = i_exc_pc_em;
      cap_tval  = i_exc_addr_em;
    end else if (fd_valid) begin
      cap_cause = {28'd0, i_exc_code_fd};
      cap_epc   = i_exc_pc_fd;
      cap_tval  = i_exc_pc_fd;
    end else if (irq_valid) begin
      if (irq[11])
        cap_cause = 32'h8000_000B;
      else if (irq[3])
        cap_cause = 32'h8000_0003;
      else
        cap_cause = 32'h8000_0007;
      cap_epc  = i_exc_pc_fd;
      cap_tval = 32'd0;
    end
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  always_comb begin
    trap_target = {i_mtvec[31:2], 2'b00};
    if (i_mtvec[1:0] == 2'b01 && o_trap_cause[31])
      trap_target = {i_mtvec[31:2], 2'b00} + {25'd0, o_trap_cause[4:0], 2'b00};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      count            <= 4'd0;
      o_stall          <= 1'b0;
      o_flush          <= 1'b0;
      o_trap_we        <= 1'b0;
      o_trap_cause     <= 32'd0;
      o_trap_epc       <= 32'd0;
      o_trap_tval      <= 32'd0;
      o_mret_we        <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= 32'd0;
    end else if (i_clk_en) begin
      o_flush          <= 1'b0;
      o_trap_we        <= 1'b0;
      o_mret_we        <= 1'b0;
      o_redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_stall <= 1'b0;
          if (trap_event) begin
            state        <= DRAIN;
            count        <= DRAIN_LOAD;
            o_stall      <= 1'b1;
            o_flush      <= 1'b1;
            o_trap_cause <= cap_cause;
            o_trap_epc   <= cap_epc;
            o_trap_tval  <= cap_tval;
          end else if (i_mret_e) begin
            state   <= RET;
            o_stall <= 1'b1;
            o_flush <= 1'b1;
          end
        end
        DRAIN: begin
          o_stall <= 1'b1;
          if (count == 4'd0)
            state <= COMMIT;
          else
            count <= count - 4'd1;
        end
        COMMIT: begin
          o_stall <= 1'b1;
          // A software CSR write owns the port this cycle; retry next cycle.
          if (!i_csr_write_en) begin
            o_trap_we     <= 1'b1;
            o_redirect_pc <= trap_target;
            state         <= REDIRECT;
          end
        end
        RET: begin
          o_stall       <= 1'b1;
          o_mret_we     <= 1'b1;
          o_redirect_pc <= i_mepc;
          state         <= REDIRECT;
        end
        REDIRECT: begin
          o_stall          <= 1'b1;
          o_redirect_valid <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          state   <= IDLE;
          o_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_trap_sequencer.sv
// Directed bench for m_trap_sequencer: linear steps, outputs sampled 1 ns after each rising edge.
module tb_m_trap_sequencer;

  localparam logic [3:0] NO_E = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [3:0]  exc_code_fd;
  logic [31:0] exc_pc_fd;
  logic [3:0]  exc_code_em;
  logic [31:0] exc_pc_em;
  logic [31:0] exc_addr_em;
  logic [31:0] irq_pending;
  logic [31:0] mie;
  logic [31:0] mstatus_lower;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mret_e;
  logic        csr_write_en;
  logic        stall;
  logic        flush;
  logic        trap_we;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  m_trap_sequencer #(.DRAIN_CYCLES(2), .NO_E_CODE(NO_E)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_clk_en        (clk_en),
    .i_exc_code_fd   (exc_code_fd),
    .i_exc_pc_fd     (exc_pc_fd),
    .i_exc_code_em   (exc_code_em),
    .i_exc_pc_em     (exc_pc_em),
    .i_exc_addr_em   (exc_addr_em),
    .i_irq_pending   (irq_pending),
    .i_mie           (mie),
    .i_mstatus_lower (mstatus_lower),
    .i_mtvec         (mtvec),
    .i_mepc          (mepc),
    .i_mret_e        (mret_e),
    .i_csr_write_en  (csr_write_en),
    .o_stall         (stall),
    .o_flush         (flush),
    .o_trap_we       (trap_we),
    .o_trap_cause    (trap_cause),
    .o_trap_epc      (trap_epc),
    .o_trap_tval     (trap_tval),
    .o_mret_we       (mret_we),
    .o_redirect_valid(redirect_valid),
    .o_redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic quiet_inputs();
    exc_code_fd  = NO_E;
    exc_code_em  = NO_E;
    irq_pending  = 32'd0;
    mret_e       = 1'b0;
    csr_write_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    quiet_inputs();
    exc_pc_fd = 32'd0; exc_pc_em = 32'd0; exc_addr_em = 32'd0;
    mie = 32'd0; mstatus_lower = 32'd0; mtvec = 32'h200; mepc = 32'd0;

    // Reset state
    apply_stimulus();
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_flush", 32'(flush), 32'd0);
    check_output("rst_trap_we", 32'(trap_we), 32'd0);
    check_output("rst_redir", 32'(redirect_valid), 32'd0);
    check_output("rst_cause", trap_cause, 32'd0);
    check_output("rst_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    apply_stimulus();

    // E/M load fault
    $display("[TB] E/M load fault");
    exc_code_em = 4'd5; exc_pc_em = 32'h100; exc_addr_em = 32'h8000_0003; mtvec = 32'h200;
    apply_stimulus();
    quiet_inputs();
    check_output("em_flush", 32'(flush), 32'd1);
    check_output("em_stall0", 32'(stall), 32'd1);
    apply_stimulus();
    check_output("em_flush_off", 32'(flush), 32'd0);
    check_output("em_stall1", 32'(stall), 32'd1);
    check_output("em_we_early1", 32'(trap_we), 32'd0);
    apply_stimulus();
    check_output("em_stall2", 32'(stall), 32'd1);
    check_output("em_we_early2", 32'(trap_we), 32'd0);
    apply_stimulus();
    check_output("em_we", 32'(trap_we), 32'd1);
    check_output("em_cause", trap_cause, 32'd5);
    check_output("em_epc", trap_epc, 32'h100);
    check_output("em_tval", trap_tval, 32'h8000_0003);
    check_output("em_redir_early", 32'(redirect_valid), 32'd0);
    apply_stimulus();
    check_output("em_we_once", 32'(trap_we), 32'd0);
    check_output("em_redir", 32'(redirect_valid), 32'd1);
    check_output("em_redir_pc", redirect_pc, 32'h200);
    check_output("em_redir_stall", 32'(stall), 32'd1);
    apply_stimulus();
    check_output("em_idle_redir", 32'(redirect_valid), 32'd0);
    check_output("em_idle_stall", 32'(stall), 32'd0);

    // Simultaneous F/D and E/M exceptions
    $display("[TB] F/D + E/M");
    exc_code_fd = 4'd2; exc_pc_fd = 32'h40;
    exc_code_em = 4'd4; exc_pc_em = 32'h80; exc_addr_em = 32'h99;
    apply_stimulus();
    quiet_inputs();
    check_output("both_flush", 32'(flush), 32'd1);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("both_we", 32'(trap_we), 32'd1);
    check_output("both_cause", trap_cause, 32'd4);
    check_output("both_epc", trap_epc, 32'h80);
    check_output("both_tval", trap_tval, 32'h99);
    apply_stimulus();
    check_output("both_we_once", 32'(trap_we), 32'd0);
    check_output("both_redir", 32'(redirect_valid), 32'd1);
    apply_stimulus();
    check_output("both_we_none", 32'(trap_we), 32'd0);
    check_output("both_idle", 32'(stall), 32'd0);

    // Vectored interrupt
    $display("[TB] interrupt");
    irq_pending = 32'h880; mie = 32'h80; mstatus_lower = 32'h8; mtvec = 32'h201; exc_pc_fd = 32'h300;
    apply_stimulus();
    quiet_inputs();
    check_output("irq_flush", 32'(flush), 32'd1);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("irq_we", 32'(trap_we), 32'd1);
    check_output("irq_cause", trap_cause, 32'h8000_0007);
    check_output("irq_epc", trap_epc, 32'h300);
    check_output("irq_tval", trap_tval, 32'd0);
    apply_stimulus();
    check_output("irq_redir", 32'(redirect_valid), 32'd1);
    check_output("irq_redir_pc", redirect_pc, 32'h21C);
    apply_stimulus();

    // Globally masked interrupt
    irq_pending = 32'h880; mstatus_lower = 32'h0;
    apply_stimulus();
    check_output("mask_flush", 32'(flush), 32'd0);
    check_output("mask_stall", 32'(stall), 32'd0);
    apply_stimulus();
    check_output("mask_stall2", 32'(stall), 32'd0);
    quiet_inputs();
    mtvec = 32'h200;

    // mret
    $display("[TB] mret");
    mepc = 32'h1234; mret_e = 1'b1;
    apply_stimulus();
    mret_e = 1'b0;
    check_output("mret_flush", 32'(flush), 32'd1);
    check_output("mret_we_early", 32'(mret_we), 32'd0);
    apply_stimulus();
    check_output("mret_we", 32'(mret_we), 32'd1);
    check_output("mret_redir_early", 32'(redirect_valid), 32'd0);
    apply_stimulus();
    check_output("mret_we_once", 32'(mret_we), 32'd0);
    check_output("mret_redir", 32'(redirect_valid), 32'd1);
    check_output("mret_redir_pc", redirect_pc, 32'h1234);
    apply_stimulus();
    check_output("mret_idle", 32'(stall), 32'd0);

    // mret together with an exception: exception wins
    $display("[TB] mret + exception");
    mret_e = 1'b1; exc_code_em = 4'd6; exc_pc_em = 32'h500; exc_addr_em = 32'h600;
    apply_stimulus();
    quiet_inputs();
    apply_stimulus();
    check_output("mx_no_mret_we", 32'(mret_we), 32'd0);
    apply_stimulus();
    apply_stimulus();
    check_output("mx_we", 32'(trap_we), 32'd1);
    check_output("mx_cause", trap_cause, 32'd6);
    apply_stimulus();
    check_output("mx_redir_pc", redirect_pc, 32'h200);
    check_output("mx_no_mret_we2", 32'(mret_we), 32'd0);
    apply_stimulus();

    // Software CSR write blocks COMMIT for 3 cycles
    $display("[TB] csr write blocks commit");
    exc_code_em = 4'd7; exc_pc_em = 32'h700; exc_addr_em = 32'h704;
    apply_stimulus();
    quiet_inputs();
    apply_stimulus();
    apply_stimulus();
    csr_write_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output($sformatf("blk_we_%0d", i), 32'(trap_we), 32'd0);
      check_output($sformatf("blk_stall_%0d", i), 32'(stall), 32'd1);
    end
    csr_write_en = 1'b0;
    apply_stimulus();
    check_output("blk_we", 32'(trap_we), 32'd1);
    check_output("blk_cause", trap_cause, 32'd7);
    check_output("blk_epc", trap_epc, 32'h700);
    check_output("blk_tval", trap_tval, 32'h704);
    apply_stimulus();
    check_output("blk_redir", 32'(redirect_valid), 32'd1);
    apply_stimulus();

    // Reset during DRAIN abandons the sequence
    $display("[TB] reset during drain");
    exc_code_em = 4'd5; exc_pc_em = 32'h100; exc_addr_em = 32'h8000_0003;
    apply_stimulus();
    quiet_inputs();
    apply_stimulus();
    rst = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    check_output("rd_stall", 32'(stall), 32'd0);
    check_output("rd_cause", trap_cause, 32'd0);
    check_output("rd_epc", trap_epc, 32'd0);
    check_output("rd_pc", redirect_pc, 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output($sformatf("rd_we_%0d", i), 32'(trap_we), 32'd0);
      check_output($sformatf("rd_redir_%0d", i), 32'(redirect_valid), 32'd0);
    end

    // Clock enable low stretches the mret strobe
    $display("[TB] clock enable hold");
    mepc = 32'h4444; mret_e = 1'b1;
    apply_stimulus();
    mret_e = 1'b0;
    apply_stimulus();
    check_output("ce_mret_we", 32'(mret_we), 32'd1);
    clk_en = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("ce_hold_we", 32'(mret_we), 32'd1);
    check_output("ce_hold_redir", 32'(redirect_valid), 32'd0);
    clk_en = 1'b1;
    apply_stimulus();
    check_output("ce_redir", 32'(redirect_valid), 32'd1);
    check_output("ce_redir_pc", redirect_pc, 32'h4444);
    check_output("ce_we_drop", 32'(mret_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
